multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Sequencing control unit for the multicycle MIPS core. It replaces the single-cycle combinational controller and shares one ALU and one unified memory across several cycles per instruction. A Moore state machine produces per-state datapath enables and mux selects from the latched opcode. It also computes `pcen` from the datapath `zero` flag.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high; forces FETCH
- `op`  in  6  opcode from instruction register (`instr[31:26]`)
- `funct`  in  6  function field from instruction register (`instr[5:0]`)
- `zero`  in  1  ALU zero flag
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `memwrite`  out  1  memory write strobe
- `irwrite`  out  1  instruction register load enable
- `regdst`  out  1  write register select: 0 = rt, 1 = rd
- `memtoreg`  out  1  write-back select: 0 = ALUOut, 1 = data register
- `regwrite`  out  1  register file write enable
- `alusrca`  out  1  ALU A select: 0 = PC, 1 = register A
- `alusrcb`  out  2  ALU B select: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- `pcsrc`  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- `alucontrol`  out  3  ALU operation
- `pcen`  out  1  PC load enable = `pcwrite | (branch & zero)` (see Configuration)
- `state`  out  4  current state encoding, for debug and bench

## Operation
State encodings:
- FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
- RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11

Transitions:
- FETCH→DECODE.
- DECODE dispatches on `op`:
  - 100011 (lw) or 101011 (sw) → MEMADR
  - 000000 (R-type) → RTYPEEX
  - 000100 (beq) → BEQEX
  - 001000 (addi) → ADDIEX
  - 000010 (j) → JEX
  - any other opcode → FETCH; the instruction is a 2-cycle no-op.
- MEMADR→MEMRD when `op` = lw, otherwise →MEMWR.
- MEMRD→MEMWB.
- RTYPEEX→RTYPEWB.
- ADDIEX→ADDIWB.
- MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX and JEX all → FETCH.
- Any unused encoding (12–15) → FETCH.

`op` and `funct` are sampled only in DECODE, MEMADR and RTYPEEX. The IR holds them stable outside FETCH.

Per-state outputs. Any output not listed for a state is 0 in that state.
- FETCH: irwrite=1, pcwrite=1, alusrcb=01, ALU add.
- DECODE: alusrcb=11, ALU add (branch target computed into ALUOut).
- MEMADR, ADDIEX: alusrca=1, alusrcb=10, ALU add.
- MEMRD: iord=1.
- MEMWR: iord=1, memwrite=1.
- MEMWB: memtoreg=1, regwrite=1.
- RTYPEEX: alusrca=1, ALU from funct.
- RTYPEWB: regdst=1, regwrite=1.
- ADDIWB: regwrite=1.
- BEQEX: alusrca=1, branch=1, pcsrc=01, ALU sub.
- JEX: pcwrite=1, pcsrc=10.

ALU encodings:
- add=010, sub=110.
- funct decode: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111; any other funct→010.

## Timing
- Reset: sampled on the rising edge. `state`=0 (FETCH) on the following cycle. Reset dominates any in-flight instruction, including one in MEMWR or a WB state. No partial write-back occurs after the reset edge, because outputs follow FETCH immediately.
- Outputs during reset and immediately after are the FETCH values: irwrite=1, pcwrite=1, pcen=1, alusrcb=01, alucontrol=010, all others 0.
- All outputs except `pcen` are a function of `state` (and `funct` in RTYPEEX). `pcen` is additionally combinational in `zero`, within the same cycle.
- Cycles per instruction, FETCH to FETCH:
  - lw 5
  - sw, R-type, addi 4
  - beq, j 3
  - unknown opcode 2

## Configuration
- `MC_BNE_EN` defined:
  - Adds state BNEEX=12. DECODE goes to BNEEX on `op`=000101.
  - BNEEX outputs are identical to BEQEX, except `pcen = branch & ~zero`.
  - BNEEX→FETCH.
- `MC_BNE_EN` undefined:
  - Opcode 000101 is treated as unknown (DECODE→FETCH).
  - Encoding 12 is unused and recovers to FETCH.

## Test plan
- Reset held 3 cycles mid-lw (asserted while `state`=3): `state`=0 on the next cycle, regwrite never asserted, irwrite=1 and pcen=1.
- lw (op=100011): state sequence 0,1,2,3,4,0. iord=1 in state 3. memtoreg=1 and regwrite=1 in state 4 only.
- sw then R-type sub (funct=100010): sw gives 0,1,2,5,0 with memwrite=1 only in state 5. R-type gives alucontrol=110 in state 6, then regdst=1 and regwrite=1 in state 7.
- beq: zero=1 gives pcen=1 and pcsrc=01 in state 8; zero=0 gives pcen=0. Next state is 0 in both cases.
- j and unknown op=111111: j gives 0,1,11,0 with pcsrc=10 and pcen=1. Unknown gives 0,1,0 with no write strobes.
- `MC_BNE_EN` build: op=000101 with zero=0 gives state 12 and pcen=1; with zero=1, pcen=0. Without the macro, the same stimulus gives 0,1,0.

Source files
------------

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_controller
//  Description : Moore sequencing controller for the multicycle MIPS core.
//                Walks each instruction through FETCH/DECODE/execute/
//                write-back states and drives the datapath enables and mux
//                selects for the state it is in. pcen combines the
//                unconditional PC write with the branch decision on zero.
//  Options     : MC_BNE_EN - adds the BNEEX state (encoding 12) for bne.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       pcen,
  output logic [3:0] state
);

  // State encodings are visible on the state port, so they are fixed values.
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
`ifdef MC_BNE_EN
    ,
    S_BNEEX   = 4'd12
`endif
  } state_t;

  // Opcodes recognised in DECODE.
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;
  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_addi  = 6'b001000;
  localparam logic [5:0] c_op_j     = 6'b000010;
`ifdef MC_BNE_EN
  localparam logic [5:0] c_op_bne   = 6'b000101;
`endif

  // R-type function codes.
  localparam logic [5:0] c_fn_add = 6'b100000;
  localparam logic [5:0] c_fn_sub = 6'b100010;
  localparam logic [5:0] c_fn_and = 6'b100100;
  localparam logic [5:0] c_fn_or  = 6'b100101;
  localparam logic [5:0] c_fn_slt = 6'b101010;

  // ALU operation codes.
  localparam logic [2:0] c_alu_add = 3'b010;
  localparam logic [2:0] c_alu_sub = 3'b110;
  localparam logic [2:0] c_alu_and = 3'b000;
  localparam logic [2:0] c_alu_or  = 3'b001;
  localparam logic [2:0] c_alu_slt = 3'b111;

  // Datapath select codes.
  localparam logic [1:0] c_srcb_reg  = 2'b00;
  localparam logic [1:0] c_srcb_four = 2'b01;
  localparam logic [1:0] c_srcb_imm  = 2'b10;
  localparam logic [1:0] c_srcb_imm2 = 2'b11;
  localparam logic [1:0] c_pc_alu    = 2'b00;
  localparam logic [1:0] c_pc_aluout = 2'b01;
  localparam logic [1:0] c_pc_jump   = 2'b10;

  state_t     r_state;
  state_t     w_next;
  logic       w_pcwrite;
  logic       w_branch;
  logic [2:0] w_funct_alu;
`ifdef MC_BNE_EN
  logic       w_bne;
`endif

  // State register; reset wins over whatever instruction is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state selection; op is only consulted in DECODE and MEMADR.
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:   w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          c_op_lw,
          c_op_sw:    w_next = S_MEMADR;
          c_op_rtype: w_next = S_RTYPEEX;
          c_op_beq:   w_next = S_BEQEX;
          c_op_addi:  w_next = S_ADDIEX;
          c_op_j:     w_next = S_JEX;
`ifdef MC_BNE_EN
          c_op_bne:   w_next = S_BNEEX;
`endif
          // Unknown opcodes retire as a two-cycle no-op.
          default:    w_next = S_FETCH;
        endcase
      end
      S_MEMADR:  w_next = (op == c_op_lw) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   w_next = S_MEMWB;
      S_RTYPEEX: w_next = S_RTYPEWB;
      S_ADDIEX:  w_next = S_ADDIWB;
      // Write-back, store, branch and jump states all return to FETCH,
      // as does any encoding the machine never uses.
      default:   w_next = S_FETCH;
    endcase
  end

  // ALU operation requested by an R-type function field.
  always_comb begin
    w_funct_alu = c_alu_add;
    case (funct)
      c_fn_add: w_funct_alu = c_alu_add;
      c_fn_sub: w_funct_alu = c_alu_sub;
      c_fn_and: w_funct_alu = c_alu_and;
      c_fn_or:  w_funct_alu = c_alu_or;
      c_fn_slt: w_funct_alu = c_alu_slt;
      default:  w_funct_alu = c_alu_add;
    endcase
  end

  // Moore outputs per state; anything not driven for a state stays 0.
  always_comb begin
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = c_srcb_reg;
    pcsrc      = c_pc_alu;
    alucontrol = 3'b000;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
`ifdef MC_BNE_EN
    w_bne      = 1'b0;
`endif
    case (r_state)
      S_FETCH: begin
        // Load IR and advance PC by 4 in the same cycle.
        irwrite    = 1'b1;
        w_pcwrite  = 1'b1;
        alusrcb    = c_srcb_four;
        alucontrol = c_alu_add;
      end
      S_DECODE: begin
        // Speculatively form the branch target into ALUOut.
        alusrcb    = c_srcb_imm2;
        alucontrol = c_alu_add;
      end
      S_MEMADR,
      S_ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = c_srcb_imm;
        alucontrol = c_alu_add;
      end
      S_MEMRD: begin
        iord = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca    = 1'b1;
        alucontrol = w_funct_alu;
      end
      S_RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
      end
      S_BEQEX: begin
        // Compare registers; the target already sits in ALUOut.
        alusrca    = 1'b1;
        w_branch   = 1'b1;
        pcsrc      = c_pc_aluout;
        alucontrol = c_alu_sub;
      end
`ifdef MC_BNE_EN
      S_BNEEX: begin
        alusrca    = 1'b1;
        w_branch   = 1'b1;
        w_bne      = 1'b1;
        pcsrc      = c_pc_aluout;
        alucontrol = c_alu_sub;
      end
`endif
      S_JEX: begin
        w_pcwrite = 1'b1;
        pcsrc     = c_pc_jump;
      end
      default: begin
        iord = 1'b0;
      end
    endcase
  end

  // PC enable follows zero combinationally in the branch states.
`ifdef MC_BNE_EN
  assign pcen = w_bne ? (w_branch & ~zero) : (w_pcwrite | (w_branch & zero));
`else
  assign pcen = w_pcwrite | (w_branch & zero);
`endif

  assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_controller
//  Description : Self-checking bench for multicycle_controller. A model
//                describes each instruction as the list of states it visits
//                and a per-state output table; it is compared with the DUT
//                every cycle under directed and random stimulus.
//                Honours MC_BNE_EN the same way as the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
    .pcen(pcen), .state(state)
  );

  always #5 clk = ~clk;

  // Output bundle: iord[14] memwrite[13] irwrite[12] regdst[11] memtoreg[10]
  // regwrite[9] alusrca[8] alusrcb[7:6] pcsrc[5:4] alucontrol[3:1] pcen[0]
  logic [14:0] cap;
  assign cap = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                alusrcb, pcsrc, alucontrol, pcen};

  int checks = 0;
  int errors = 0;
  bit started = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // States visited after FETCH for an opcode (element 0 is DECODE).
  function automatic logic [3:0][3:0] path_of(input logic [5:0] o);
    logic [3:0][3:0] p;
    p = '0;
    p[0] = 4'd1;
    case (o)
      6'b100011: begin p[1] = 4'd2; p[2] = 4'd3; p[3] = 4'd4; end
      6'b101011: begin p[1] = 4'd2; p[2] = 4'd5; end
      6'b000000: begin p[1] = 4'd6; p[2] = 4'd7; end
      6'b000100: p[1] = 4'd8;
      6'b001000: begin p[1] = 4'd9; p[2] = 4'd10; end
      6'b000010: p[1] = 4'd11;
`ifdef MC_BNE_EN
      6'b000101: p[1] = 4'd12;
`endif
      default: p[1] = 4'd0;
    endcase
    return p;
  endfunction

  // Instruction length in cycles, FETCH excluded.
  function automatic int path_len(input logic [5:0] o);
    case (o)
      6'b100011: return 4;
      6'b101011, 6'b000000, 6'b001000: return 3;
      6'b000100, 6'b000010: return 2;
`ifdef MC_BNE_EN
      6'b000101: return 2;
`endif
      default: return 1;
    endcase
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected outputs from the per-state table.
  function automatic logic [14:0] exp_out(input logic [3:0] s, input logic [5:0] f, input logic z);
    logic io, mw, irw, rd, mtr, rw, asa, pw, br, bn;
    logic [1:0] asb, ps;
    logic [2:0] alu;
    logic pe;
    {io, mw, irw, rd, mtr, rw, asa, pw, br, bn} = '0;
    asb = 2'b00; ps = 2'b00; alu = 3'b000;
    case (s)
      4'd0:  begin irw = 1; pw = 1; asb = 2'b01; alu = 3'b010; end
      4'd1:  begin asb = 2'b11; alu = 3'b010; end
      4'd2, 4'd9: begin asa = 1; asb = 2'b10; alu = 3'b010; end
      4'd3:  io = 1;
      4'd4:  begin mtr = 1; rw = 1; end
      4'd5:  begin io = 1; mw = 1; end
      4'd6:  begin asa = 1; alu = funct_alu(f); end
      4'd7:  begin rd = 1; rw = 1; end
      4'd8:  begin asa = 1; br = 1; ps = 2'b01; alu = 3'b110; end
      4'd10: rw = 1;
      4'd11: begin pw = 1; ps = 2'b10; end
`ifdef MC_BNE_EN
      4'd12: begin asa = 1; br = 1; bn = 1; ps = 2'b01; alu = 3'b110; end
`endif
      default: ;
    endcase
    pe = bn ? (br & ~z) : (pw | (br & z));
    return {io, mw, irw, rd, mtr, rw, asa, asb, ps, alu, pe};
  endfunction

  // Model state: position within the current instruction's state list.
  logic [3:0]      m_state;
  logic [3:0][3:0] m_path;
  int              m_len;
  int              m_idx;

  always @(posedge clk) begin
    if (reset) begin
      m_state <= 4'd0;
      m_idx   <= 0;
    end else if (m_state == 4'd0) begin
      m_path  <= path_of(op);
      m_len   <= path_len(op);
      m_state <= 4'd1;
      m_idx   <= 1;
    end else if (m_idx < m_len) begin
      m_state <= m_path[m_idx];
      m_idx   <= m_idx + 1;
    end else begin
      m_state <= 4'd0;
    end
  end

  // Every-cycle comparison against the model, away from the clock edge.
  always @(negedge clk) begin
    if (started) begin
      chk("state_vs_model", {28'd0, state}, {28'd0, m_state});
      chk("outputs_vs_model", {17'd0, cap}, {17'd0, exp_out(m_state, funct, zero)});
    end
  end

  logic [14:0] s_out [8];

  // Runs one instruction from FETCH and checks the literal state sequence.
  task automatic run_seq(input string name, input logic [5:0] o, input logic [5:0] f,
                         input logic z, input logic [23:0] seq, input int n);
    int cnt = 0;
    while (m_state != 4'd0 && cnt < 20) begin
      @(posedge clk); #1; cnt++;
    end
    chk({name, "_reach_fetch"}, {31'd0, m_state == 4'd0}, 32'd1);
    op = o; funct = f; zero = z;
    #1;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        @(posedge clk); #2;
      end
      s_out[i] = cap;
      chk({name, "_state"}, {28'd0, state}, {28'd0, seq[i*4 +: 4]});
    end
  endtask

  function automatic logic [7:0] col(input int b, input int n);
    logic [7:0] v = '0;
    for (int i = 0; i < n; i++) v[i] = s_out[i][b];
    return v;
  endfunction

  logic [5:0] ftab [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

  initial begin
    logic sawrw;
    reset = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    started = 1;
    #1;
    chk("reset_state", {28'd0, state}, 32'd0);
    chk("reset_outputs", {17'd0, cap}, 32'h1045);

    run_seq("lw", 6'b100011, 6'd0, 1'b0, 24'h043210, 6);
    chk("lw_iord", {24'd0, col(14, 6)}, 32'h08);
    chk("lw_regwrite", {24'd0, col(9, 6)}, 32'h10);
    chk("lw_memtoreg", {24'd0, col(10, 6)}, 32'h10);

    run_seq("sw", 6'b101011, 6'd0, 1'b0, 24'h005210, 5);
    chk("sw_memwrite", {24'd0, col(13, 5)}, 32'h08);

    run_seq("rsub", 6'b000000, 6'b100010, 1'b0, 24'h007610, 5);
    chk("rsub_alu", {29'd0, s_out[2][3:1]}, 32'd6);
    chk("rsub_regdst", {24'd0, col(11, 5)}, 32'h08);
    chk("rsub_regwrite", {24'd0, col(9, 5)}, 32'h08);

    run_seq("beq_z1", 6'b000100, 6'd0, 1'b1, 24'h000810, 4);
    chk("beq_z1_pcen", {31'd0, s_out[2][0]}, 32'd1);
    chk("beq_z1_pcsrc", {30'd0, s_out[2][5:4]}, 32'd1);
    run_seq("beq_z0", 6'b000100, 6'd0, 1'b0, 24'h000810, 4);
    chk("beq_z0_pcen", {31'd0, s_out[2][0]}, 32'd0);

    run_seq("j", 6'b000010, 6'd0, 1'b0, 24'h000B10, 4);
    chk("j_pcsrc", {30'd0, s_out[2][5:4]}, 32'd2);
    chk("j_pcen", {31'd0, s_out[2][0]}, 32'd1);

    run_seq("unk", 6'b111111, 6'd0, 1'b0, 24'h000010, 3);
    chk("unk_memwrite", {24'd0, col(13, 3)}, 32'h0);
    chk("unk_regwrite", {24'd0, col(9, 3)}, 32'h0);
    chk("unk_irwrite", {24'd0, col(12, 3)}, 32'h05);

`ifdef MC_BNE_EN
    run_seq("bne_z0", 6'b000101, 6'd0, 1'b0, 24'h000C10, 4);
    chk("bne_z0_pcen", {31'd0, s_out[2][0]}, 32'd1);
    run_seq("bne_z1", 6'b000101, 6'd0, 1'b1, 24'h000C10, 4);
    chk("bne_z1_pcen", {31'd0, s_out[2][0]}, 32'd0);
`else
    run_seq("bne_off", 6'b000101, 6'd0, 1'b0, 24'h000010, 3);
`endif

    // Reset held three cycles while a lw sits in MEMRD.
    run_seq("lw_rst", 6'b100011, 6'd0, 1'b0, 24'h003210, 4);
    sawrw = 1'b0;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #2;
      sawrw |= regwrite;
      chk("rst_hold_state", {28'd0, state}, 32'd0);
      chk("rst_hold_irwrite", {31'd0, irwrite}, 32'd1);
      chk("rst_hold_pcen", {31'd0, pcen}, 32'd1);
    end
    reset = 1'b0;
    @(posedge clk); #2;
    sawrw |= regwrite;
    chk("rst_release_state", {28'd0, state}, 32'd1);
    chk("rst_no_regwrite", {31'd0, sawrw}, 32'd0);

    // Random instruction mix with random zero and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      reset = ($urandom_range(0, 60) == 0);
      zero  = 1'($urandom);
      if (m_state == 4'd0) begin
        case ($urandom_range(0, 8))
          0: op = 6'b100011;
          1: op = 6'b101011;
          2: op = 6'b000000;
          3: op = 6'b000100;
          4: op = 6'b001000;
          5: op = 6'b000010;
          6: op = 6'b000101;
          7: op = 6'b111111;
          default: op = 6'($urandom);
        endcase
        if ($urandom_range(0, 5) == 5) funct = 6'($urandom);
        else funct = ftab[$urandom_range(0, 4)];
      end
    end
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #6;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
